// File: rtl/johnson_phase_tracker_pkg.sv
// Shared types and Johnson-code helpers for the phase tracker.
// Helpers take the ring width n explicitly so any instance width up to MAXN can use them.
package johnson_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam int MAXN = 32;

  function automatic int jc_popcount(input logic [MAXN-1:0] code, input int n);
    int p;
    p = 0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < n && code[i]) p++;
    end
    return p;
  endfunction

  // LSB=0: ones packed against the MSB; LSB=1: ones packed against the LSB.
  function automatic logic jc_is_legal(input logic [MAXN-1:0] code, input int n);
    int   p;
    logic ok;
    logic e;
    p  = jc_popcount(code, n);
    ok = 1'b1;
    for (int i = 0; i < MAXN; i++) begin
      if (i < n) begin
        e = code[0] ? (i < p) : (i >= n - p);
        if (code[i] != e) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic int jc_to_idx(input logic [MAXN-1:0] code, input int n);
    int p;
    p = jc_popcount(code, n);
    return code[0] ? (2 * n - p) : p;
  endfunction

  function automatic int jc_next_idx(input int idx, input int n);
    return (idx >= 2 * n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/johnson_phase_tracker_if.sv
// Signal bundle between the Johnson counter side and the phase tracker.
// No valid/ready handshake: code_in is taken every clk, outputs are updated every clk.
interface johnson_phase_tracker_if #(
  parameter int N  = 4,
  parameter int CW = 16
);
  import johnson_pkg::*;

  localparam int IW = $clog2(2 * N);

  logic [N-1:0]   code_in;
  logic           clr_err;
  logic [IW-1:0]  phase_idx;
  logic [2*N-1:0] phase_onehot;
  logic           phase_valid;
  logic           locked;
  logic           err_illegal;
  logic           err_seq;
  logic           wrap_pulse;
  logic [CW-1:0]  wrap_count;
  state_t         dbg_state;

  modport master (
    output code_in, clr_err,
    input  phase_idx, phase_onehot, phase_valid, locked,
    input  err_illegal, err_seq, wrap_pulse, wrap_count, dbg_state
  );

  modport slave (
    input  code_in, clr_err,
    output phase_idx, phase_onehot, phase_valid, locked,
    output err_illegal, err_seq, wrap_pulse, wrap_count, dbg_state
  );

endinterface

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code -> {legal, phase index}; index forced to 0 when illegal.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code,
  output logic          legal,
  output logic [IW-1:0] idx
);

  logic [MAXN-1:0] code_w;

  always_comb begin
    code_w = MAXN'(code);
    legal  = jc_is_legal(code_w, N);
    idx    = legal ? IW'(jc_to_idx(code_w, N)) : '0;
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Tracks a free-running Johnson counter: decodes each sample, checks successor order,
// locks after LOCK_CNT good transitions, flags faults and counts full rings.
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int CW       = 16
) (
  input logic                   clk,
  input logic                   rst,
  johnson_phase_tracker_if.slave bus
);

  localparam int IW = $clog2(2 * N);
  localparam int PW = 2 * N;
  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);

  state_t         state, state_n;
  logic [GW-1:0]  good_run, good_run_n;
  logic           prev_vld, prev_vld_n;
  logic [IW-1:0]  prev_idx, prev_idx_n;
  logic           legal_c;
  logic [IW-1:0]  idx_c;
  logic           succ;
  logic           wrap_n, set_ill, set_seq;

  logic [IW-1:0]  phase_idx_r;
  logic [PW-1:0]  phase_onehot_r;
  logic           phase_valid_r, err_illegal_r, err_seq_r, wrap_pulse_r;
  logic [CW-1:0]  wrap_count_r;

  johnson_code_decode #(.N(N), .IW(IW)) u_decode (
    .code  (bus.code_in),
    .legal (legal_c),
    .idx   (idx_c)
  );

  assign succ = prev_vld && (idx_c == IW'(jc_next_idx(int'(prev_idx), N)));

  always_comb begin
    state_n    = state;
    good_run_n = good_run;
    prev_vld_n = legal_c;
    prev_idx_n = legal_c ? idx_c : prev_idx;
    wrap_n     = 1'b0;
    set_ill    = !legal_c;
    set_seq    = (state == LOCKED) && legal_c && !succ;
    case (state)
      ACQ: begin
        // Wrong successor only restarts acquisition; it is not an error here.
        if (legal_c && succ) begin
          if (good_run == GW'(LOCK_CNT - 1)) begin
            state_n    = LOCKED;
            good_run_n = '0;
          end else begin
            good_run_n = good_run + 1'b1;
          end
        end else begin
          good_run_n = '0;
        end
      end
      LOCKED: begin
        if (!legal_c || !succ) state_n = FAULT;
        else                   wrap_n  = (prev_idx == IW'(PW - 1));
      end
      FAULT: begin
        // A fresh illegal sample beats clr_err and keeps us in FAULT.
        if (bus.clr_err && legal_c) begin
          state_n    = ACQ;
          good_run_n = '0;
          prev_vld_n = 1'b0;
        end
      end
      default: begin
        state_n    = ACQ;
        good_run_n = '0;
        prev_vld_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACQ;
      good_run       <= '0;
      prev_vld       <= 1'b0;
      prev_idx       <= '0;
      phase_idx_r    <= '0;
      phase_onehot_r <= '0;
      phase_valid_r  <= 1'b0;
      err_illegal_r  <= 1'b0;
      err_seq_r      <= 1'b0;
      wrap_pulse_r   <= 1'b0;
      wrap_count_r   <= '0;
    end else begin
      state          <= state_n;
      good_run       <= good_run_n;
      prev_vld       <= prev_vld_n;
      prev_idx       <= prev_idx_n;
      phase_idx_r    <= idx_c;
      phase_onehot_r <= legal_c ? (PW'(1) << idx_c) : '0;
      phase_valid_r  <= legal_c;
      err_illegal_r  <= set_ill | (err_illegal_r & ~bus.clr_err);
      err_seq_r      <= set_seq | (err_seq_r & ~bus.clr_err);
      wrap_pulse_r   <= wrap_n;
      wrap_count_r   <= wrap_count_r + CW'(wrap_n);
    end
  end

  assign bus.phase_idx    = phase_idx_r;
  assign bus.phase_onehot = phase_onehot_r;
  assign bus.phase_valid  = phase_valid_r;
  assign bus.locked       = (state == LOCKED);
  assign bus.err_illegal  = err_illegal_r;
  assign bus.err_seq      = err_seq_r;
  assign bus.wrap_pulse   = wrap_pulse_r;
  assign bus.wrap_count   = wrap_count_r;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Directed bench for johnson_phase_tracker: two instances (CW=16 and CW=4) share one stimulus.
module tb_johnson_phase_tracker;
  import johnson_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   nwrap = 0;
  logic [3:0] ring [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};

  johnson_phase_tracker_if #(.N(4), .CW(16)) bus  ();
  johnson_phase_tracker_if #(.N(4), .CW(4))  bus4 ();

  johnson_phase_tracker #(.N(4), .LOCK_CNT(2), .CW(16)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );
  johnson_phase_tracker #(.N(4), .LOCK_CNT(2), .CW(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one sample, return 1 time unit after the capturing edge
  task automatic drive(input logic [3:0] c, input logic clr, input logic r);
    @(negedge clk);
    rst          = r;
    bus.code_in  = c;
    bus.clr_err  = clr;
    bus4.code_in = c;
    bus4.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.code_in = '0;  bus.clr_err = 1'b0;
    bus4.code_in = '0; bus4.clr_err = 1'b0;
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);

    // reset state
    chk("rst_valid",  32'(bus.phase_valid),  32'd0);
    chk("rst_idx",    32'(bus.phase_idx),    32'd0);
    chk("rst_onehot", 32'(bus.phase_onehot), 32'd0);
    chk("rst_locked", 32'(bus.locked),       32'd0);
    chk("rst_errs",   32'({bus.err_illegal, bus.err_seq, bus.wrap_pulse}), 32'd0);
    chk("rst_wcount", 32'(bus.wrap_count),   32'd0);
    chk("rst_state",  32'(bus.dbg_state),    32'(ACQ));

    // true ring from 0000: lock after two good transitions
    for (int k = 0; k < 8; k++) begin
      drive(ring[k], 1'b0, 1'b0);
      chk("t1_valid",  32'(bus.phase_valid),  32'd1);
      chk("t1_idx",    32'(bus.phase_idx),    32'(k));
      chk("t1_onehot", 32'(bus.phase_onehot), 32'd1 << k);
      chk("t1_locked", 32'(bus.locked),       (k >= 2) ? 32'd1 : 32'd0);
    end

    // first wrap 0001 -> 0000
    drive(ring[0], 1'b0, 1'b0);
    nwrap = 1;
    chk("t2_pulse",  32'(bus.wrap_pulse), 32'd1);
    chk("t2_wcount", 32'(bus.wrap_count), 32'd1);
    drive(ring[1], 1'b0, 1'b0);
    chk("t2_pulse_off", 32'(bus.wrap_pulse), 32'd0);
    for (int k = 2; k < 8; k++) drive(ring[k], 1'b0, 1'b0);
    for (int r = 0; r < 19; r++) begin
      for (int k = 0; k < 8; k++) begin
        drive(ring[k], 1'b0, 1'b0);
        if (k == 0) begin
          nwrap++;
          if (nwrap == 15) chk("t5_w4_15", 32'(bus4.wrap_count), 32'd15);
          if (nwrap == 16) chk("t5_w4_roll", 32'(bus4.wrap_count), 32'd0);
        end
      end
    end
    chk("t2_wcount20", 32'(bus.wrap_count),  32'd20);
    chk("t5_w4_20",    32'(bus4.wrap_count), 32'd4);

    // illegal code while locked
    drive(4'b1010, 1'b0, 1'b0);
    chk("t3_valid",  32'(bus.phase_valid),  32'd0);
    chk("t3_onehot", 32'(bus.phase_onehot), 32'd0);
    chk("t3_idx",    32'(bus.phase_idx),    32'd0);
    chk("t3_ill",    32'(bus.err_illegal),  32'd1);
    chk("t3_locked", 32'(bus.locked),       32'd0);
    chk("t3_state",  32'(bus.dbg_state),    32'(FAULT));
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        drive(ring[k], 1'b0, 1'b0);
        chk("t3_nopulse", 32'(bus.wrap_pulse), 32'd0);
      end
    end
    chk("t3_wcount", 32'(bus.wrap_count), 32'd20);
    chk("t3_ill_sticky", 32'(bus.err_illegal), 32'd1);

    // clear, then relock
    drive(ring[0], 1'b1, 1'b0);
    chk("t3_clr_ill",   32'(bus.err_illegal), 32'd0);
    chk("t3_clr_state", 32'(bus.dbg_state),   32'(ACQ));
    drive(ring[1], 1'b0, 1'b0);
    drive(ring[2], 1'b0, 1'b0);
    chk("t3_notyet", 32'(bus.locked), 32'd0);
    drive(ring[3], 1'b0, 1'b0);
    chk("t3_relock", 32'(bus.locked), 32'd1);
    for (int k = 4; k < 8; k++) drive(ring[k], 1'b0, 1'b0);
    drive(ring[0], 1'b0, 1'b0);
    chk("t3_wrap_again", 32'(bus.wrap_pulse), 32'd1);
    chk("t3_wcount21",   32'(bus.wrap_count), 32'd21);
    chk("t3_w4_5",       32'(bus4.wrap_count), 32'd5);

    // hold on 1100 while locked, clr_err on the same edge
    drive(ring[1], 1'b0, 1'b0);
    drive(ring[2], 1'b0, 1'b0);
    drive(ring[2], 1'b1, 1'b0);
    chk("t4_seq",    32'(bus.err_seq),     32'd1);
    chk("t4_locked", 32'(bus.locked),      32'd0);
    chk("t4_state",  32'(bus.dbg_state),   32'(FAULT));
    chk("t4_idx",    32'(bus.phase_idx),   32'd2);
    chk("t4_ill",    32'(bus.err_illegal), 32'd0);
    drive(ring[2], 1'b0, 1'b0);
    chk("t4_sticky", 32'(bus.err_seq), 32'd1);
    drive(ring[3], 1'b1, 1'b0);
    chk("t4_clr",       32'(bus.err_seq),   32'd0);
    chk("t4_clr_state", 32'(bus.dbg_state), 32'(ACQ));

    // relock, wrap, then reset mid-ring
    for (int k = 4; k < 8; k++) drive(ring[k], 1'b0, 1'b0);
    chk("t5_locked", 32'(bus.locked), 32'd1);
    drive(ring[0], 1'b0, 1'b0);
    chk("t5_wcount22", 32'(bus.wrap_count), 32'd22);
    drive(ring[1], 1'b0, 1'b0);
    drive(ring[2], 1'b0, 1'b1);
    chk("t5_rst_valid",  32'(bus.phase_valid),  32'd0);
    chk("t5_rst_idx",    32'(bus.phase_idx),    32'd0);
    chk("t5_rst_onehot", 32'(bus.phase_onehot), 32'd0);
    chk("t5_rst_locked", 32'(bus.locked),       32'd0);
    chk("t5_rst_wcount", 32'(bus.wrap_count),   32'd0);
    chk("t5_rst_w4",     32'(bus4.wrap_count),  32'd0);
    drive(ring[3], 1'b0, 1'b0);
    chk("t5_valid", 32'(bus.phase_valid), 32'd1);
    chk("t5_idx3",  32'(bus.phase_idx),   32'd3);
    drive(ring[4], 1'b0, 1'b0);
    chk("t5_one_tr", 32'(bus.locked), 32'd0);
    drive(ring[5], 1'b0, 1'b0);
    chk("t5_relock", 32'(bus.locked), 32'd1);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
